// File: rtl/fir_pkg.sv
// Shared definitions for the folded FIR family: FSM states, width helpers
// and saturation limits.
package fir_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      OUT  = 2'd2
   } fir_state_t;

   // Ceiling log2, usable in parameter and port-width expressions.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = n - 1; v > 0; v = v >> 1) r++;
      return r;
   endfunction

   // Accumulator wide enough that summing taps full-precision products can never overflow.
   function automatic int acc_width(input int word_size, input int coef_size, input int taps);
      return word_size + coef_size + clog2(taps);
   endfunction

   // Largest value representable in a w-bit signed word.
   function automatic longint sat_max(input int w);
      return (longint'(1) <<< (w - 1)) - 1;
   endfunction

   // Smallest value representable in a w-bit signed word.
   function automatic longint sat_min(input int w);
      return -(longint'(1) <<< (w - 1));
   endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational round-half-up and saturate from an accumulator word down to
// a sample word. Shared by the filter blocks that produce WORD_SIZE outputs.
module fir_round_sat
   import fir_pkg::*;
#(
   parameter int ACC_W     = 19,
   parameter int WORD_SIZE = 8,
   parameter int FRAC_BITS = 6
) (
   input  logic signed [ACC_W-1:0]     acc,
   output logic signed [WORD_SIZE-1:0] y
);

   // One guard bit so adding the rounding constant can never wrap.
   localparam int SW = ACC_W + 1;
   localparam logic signed [SW-1:0] HALF = SW'(longint'(1) <<< (FRAC_BITS - 1));
   localparam logic signed [SW-1:0] HI   = SW'(sat_max(WORD_SIZE));
   localparam logic signed [SW-1:0] LO   = SW'(sat_min(WORD_SIZE));

   logic signed [SW-1:0] biased;
   logic signed [SW-1:0] shifted;

   // Bias by half an LSB, drop the fraction, then clamp to the sample range.
   always_comb begin
      biased  = SW'(acc) + HALF;
      shifted = biased >>> FRAC_BITS;
      if (shifted > HI) begin
         y = HI[WORD_SIZE-1:0];
      end else if (shifted < LO) begin
         y = LO[WORD_SIZE-1:0];
      end else begin
         y = shifted[WORD_SIZE-1:0];
      end
   end

endmodule

// File: rtl/fir_fold.sv
// Folded direct-form FIR: one multiply-accumulate shared across all taps,
// run-time loadable coefficients, rounded and saturated output.
//
// Handshake: a sample transfers on a rising edge where in_valid and in_ready
// are both high; in_ready is high only while idle, so the source must hold
// filter_in/in_valid until it sees in_ready. out_valid is a single-cycle
// strobe with no backpressure; filter_out holds between strobes.
module fir_fold
   import fir_pkg::*;
#(
   parameter int WORD_SIZE = 8,
   parameter int COEF_SIZE = 8,
   parameter int TAPS      = 8,
   parameter int FRAC_BITS = 6
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic signed [WORD_SIZE-1:0] filter_in,
   input  logic                        coef_we,
   input  logic [clog2(TAPS)-1:0]      coef_addr,
   input  logic signed [COEF_SIZE-1:0] coef_data,
   output logic                        out_valid,
   output logic signed [WORD_SIZE-1:0] filter_out,
   output logic                        busy
);

   localparam int AW    = clog2(TAPS);
   localparam int PW    = WORD_SIZE + COEF_SIZE;
   localparam int ACC_W = acc_width(WORD_SIZE, COEF_SIZE, TAPS);

   fir_state_t state, state_nxt;

   logic signed [WORD_SIZE-1:0] x [TAPS];
   logic signed [COEF_SIZE-1:0] c [TAPS];
   logic signed [ACC_W-1:0]     acc;
   logic [AW-1:0]               idx;
   logic signed [PW-1:0]        prod;
   logic signed [WORD_SIZE-1:0] rounded;
   logic                        accept;
   logic                        coef_ok;
   logic                        last_tap;

   assign in_ready = (state == IDLE);
   assign busy     = (state == MAC) || (state == OUT);
   assign accept   = in_valid && in_ready;
   // Writes land only while idle, and only for addresses that map to a tap.
   assign coef_ok  = coef_we && in_ready && ({1'b0, coef_addr} < (AW + 1)'(TAPS));
   assign last_tap = (idx == AW'(TAPS - 1));
   assign prod     = PW'(x[idx]) * PW'(c[idx]);

   fir_round_sat #(
      .ACC_W    (ACC_W),
      .WORD_SIZE(WORD_SIZE),
      .FRAC_BITS(FRAC_BITS)
   ) u_round_sat (
      .acc(acc),
      .y  (rounded)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state: accept -> walk every tap once -> publish -> back to idle.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = MAC;
         MAC:     if (last_tap) state_nxt = OUT;
         OUT:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Delay line, coefficient file, accumulator and output register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < TAPS; k++) begin
            x[k] <= '0;
            c[k] <= '0;
         end
         acc        <= '0;
         idx        <= '0;
         filter_out <= '0;
         out_valid  <= 1'b0;
      end else begin
         out_valid <= (state == OUT);
         if (coef_ok) c[coef_addr] <= coef_data;
         if (accept) begin
            for (int k = TAPS - 1; k > 0; k--) x[k] <= x[k-1];
            x[0] <= filter_in;
            acc  <= '0;
            idx  <= '0;
         end
         if (state == MAC) begin
            acc <= acc + ACC_W'(prod);
            idx <= last_tap ? '0 : idx + AW'(1);
         end
         if (state == OUT) filter_out <= rounded;
      end
   end

endmodule
